fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory address and loads the IF/ID register.

---
 rtl/fetch_stage_if.sv | 8 +
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the IF stage and imem
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   modport master(output imem_addr, input imem_rdata, imem_ready);
   modport slave(input imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC, the IF/ID register and a fetch-bubble counter
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic [1:0]         id_pc_src,
   input  logic [31:0]        id_jr_target,
   input  logic               ex_branch_taken,
   input  logic [31:0]        ex_branch_target,
   fetch_stage_if.master      imem,
   output logic [31:0]        if_id_instr,
   output logic [31:0]        if_id_pc_plus4,
   output logic               if_id_valid,
   output logic               flush_id_ex,
   output logic [CNT_W-1:0]   bubble_cnt
);
   logic [31:0]      pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc_plus4, jump_target;
   logic             valid_q, valid_d, jump, bubble, hold;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state selection: branch in EX beats stall, stall beats ID jump, jump beats imem wait
   always_comb begin
      pc_plus4    = pc_q + 32'd4;
      jump        = valid_q && id_pc_src[1];
      jump_target = id_pc_src[0] ? id_jr_target : {pc4_q[31:28], instr_q[25:0], 2'b00};
      hold        = !ex_branch_taken && stall;
      bubble      = ex_branch_taken || (!stall && (jump || !imem.imem_ready));
      pc_d        = ex_branch_taken ? ex_branch_target :
                    stall           ? pc_q :
                    jump            ? jump_target :
                    !imem.imem_ready ? pc_q : pc_plus4;
      instr_d     = hold ? instr_q : bubble ? NOP_INSTR : imem.imem_rdata;
      pc4_d       = hold ? pc4_q : bubble ? 32'h0 : pc_plus4;
      valid_d     = hold ? valid_q : !bubble;
      cnt_d       = (bubble && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
   end

   // PC, IF/ID and bubble counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem.imem_addr = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pc4_q;
   assign if_id_valid    = valid_q;
   assign bubble_cnt     = cnt_q;
   assign flush_id_ex    = ex_branch_taken;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed check of fetch_stage plus a counter saturation sequence
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset, stall, ex_branch_taken;
   logic [1:0]  id_pc_src;
   logic [31:0] id_jr_target, ex_branch_target;
   logic [31:0] if_id_instr, if_id_pc_plus4, if_id_instr2, if_id_pc_plus42;
   logic        if_id_valid, flush_id_ex, if_id_valid2, flush_id_ex2;
   logic [15:0] bubble_cnt;
   logic [1:0]  bubble_cnt2;
   int          checks = 0, errors = 0;

   fetch_stage_if ifc();
   fetch_stage_if ifc2();

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .id_pc_src(id_pc_src),
      .id_jr_target(id_jr_target), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .imem(ifc.master),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .flush_id_ex(flush_id_ex), .bubble_cnt(bubble_cnt)
   );

   fetch_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .stall(stall), .id_pc_src(id_pc_src),
      .id_jr_target(id_jr_target), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .imem(ifc2.master),
      .if_id_instr(if_id_instr2), .if_id_pc_plus4(if_id_pc_plus42),
      .if_id_valid(if_id_valid2), .flush_id_ex(flush_id_ex2), .bubble_cnt(bubble_cnt2)
   );

   typedef struct {
      logic        rst, stall;
      logic [1:0]  src;
      logic [31:0] jr;
      logic        bt;
      logic [31:0] btgt;
      logic        rdy;
      logic [31:0] rdata, pc, instr, pc4;
      logic        valid;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stl, input logic [1:0] src, input logic [31:0] jr,
                      input logic bt, input logic [31:0] btgt, input logic rdy, input logic [31:0] rdata,
                      input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic valid, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.stall = stl; v.src = src; v.jr = jr; v.bt = bt; v.btgt = btgt;
      v.rdy = rdy; v.rdata = rdata; v.pc = pc; v.instr = instr; v.pc4 = pc4;
      v.valid = valid; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      //  rst stl src jr            bt btgt          rdy rdata          pc            instr         pc4           v  cnt
      add(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0000, 32'h4,        32'hA000_0000, 32'h4,       1, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0004, 32'h8,        32'hA000_0004, 32'h8,       1, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0008, 32'hC,        32'hA000_0008, 32'hC,       1, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_000C, 32'h10,       32'hA000_000C, 32'h10,      1, 0);
      add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h1234_5678, 32'h10,       32'hA000_000C, 32'h10,      1, 0);
      add(0, 1, 2, 32'h0,         0, 32'h0,        0, 32'h1234_5678, 32'h10,       32'hA000_000C, 32'h10,      1, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0800_0040, 32'h14,       32'h0800_0040, 32'h14,      1, 0);
      add(0, 0, 0, 32'h0,         1, 32'h1000_0004, 1, 32'h5555_5555, 32'h1000_0004, 32'h0,      32'h0,        0, 1);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0800_0040, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1, 1);
      add(0, 0, 2, 32'h0,         0, 32'h0,        1, 32'h6666_6666, 32'h1000_0100, 32'h0,       32'h0,        0, 2);
      add(0, 0, 2, 32'h0,         0, 32'h0,        1, 32'hA100_0100, 32'h1000_0104, 32'hA100_0100, 32'h1000_0104, 1, 2);
      add(0, 1, 3, 32'h999,       1, 32'h200,      1, 32'h7777_7777, 32'h200,      32'h0,        32'h0,        0, 3);
      add(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h8888_8888, 32'h200,      32'h0,        32'h0,        0, 4);
      add(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h8888_8888, 32'h200,      32'h0,        32'h0,        0, 5);
      add(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h8888_8888, 32'h200,      32'h0,        32'h0,        0, 6);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0200, 32'h204,      32'hA000_0200, 32'h204,     1, 6);
      add(0, 0, 3, 32'h80,        0, 32'h0,        0, 32'h9999_9999, 32'h80,       32'h0,        32'h0,        0, 7);
      add(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h9999_9999, 32'h80,       32'h0,        32'h0,        0, 8);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0080, 32'h84,       32'hA000_0080, 32'h84,      1, 8);
      add(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        0, 9);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA00F_FFFC, 32'h0,        32'hA00F_FFFC, 32'h0,       1, 9);
      add(0, 0, 0, 32'h0,         1, 32'h303,      1, 32'h0,         32'h303,      32'h0,        32'h0,        0, 10);
      add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h0,         32'h303,      32'h0,        32'h0,        0, 10);
      add(1, 1, 3, 32'h44,        1, 32'h500,      0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hA000_0000, 32'h4,        32'hA000_0000, 32'h4,       1, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; stall = vecs[i].stall; id_pc_src = vecs[i].src;
         id_jr_target = vecs[i].jr; ex_branch_taken = vecs[i].bt; ex_branch_target = vecs[i].btgt;
         ifc.imem_ready = vecs[i].rdy; ifc.imem_rdata = vecs[i].rdata;
         ifc2.imem_ready = vecs[i].rdy; ifc2.imem_rdata = vecs[i].rdata;
         #1;
         chk("flush_id_ex", i, {31'h0, flush_id_ex}, {31'h0, vecs[i].bt});
         @(posedge clk);
         #1;
         chk("pc", i, ifc.imem_addr, vecs[i].pc);
         chk("if_id_instr", i, if_id_instr, vecs[i].instr);
         chk("if_id_pc_plus4", i, if_id_pc_plus4, vecs[i].pc4);
         chk("if_id_valid", i, {31'h0, if_id_valid}, {31'h0, vecs[i].valid});
         chk("bubble_cnt", i, {16'h0, bubble_cnt}, {16'h0, vecs[i].cnt});
      end

      // Saturation of a 2-bit bubble counter under a long imem wait
      @(negedge clk);
      reset = 1'b1; stall = 1'b0; id_pc_src = 2'b00; ex_branch_taken = 1'b0;
      ifc2.imem_ready = 1'b1; ifc.imem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_reset", 0, {30'h0, bubble_cnt2}, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         reset = 1'b0; ifc2.imem_ready = 1'b0; ifc.imem_ready = 1'b0;
         @(posedge clk);
         #1;
         chk("sat_cnt", k, {30'h0, bubble_cnt2}, (k > 3) ? 32'd3 : k);
         chk("sat_pc_hold", k, ifc2.imem_addr, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
